// File: rtl/decode_issue.sv
// decode_issue: decode/operand-fetch stage with register file, RAW scoreboard and one issue slot.
// Optional macro DECODE_WB_BYPASS_EN forwards same-cycle writeback data into operand reads.
package decode_issue_pkg;
    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic [3:0] {
        FUNC_ADD  = 4'd0,
        FUNC_SUB  = 4'd1,
        FUNC_AND  = 4'd2,
        FUNC_OR   = 4'd3,
        FUNC_XOR  = 4'd4,
        FUNC_NOT  = 4'd5,
        FUNC_ADDI = 4'd6,
        FUNC_SLL  = 4'd7,
        FUNC_SLLI = 4'd8,
        FUNC_SLR  = 4'd9,
        FUNC_SLRI = 4'd10
    } func_t;
endpackage

module decode_issue #(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned REG_AW     = $clog2(NUM_REGS),
    parameter int unsigned DATA_WIDTH = decode_issue_pkg::DATA_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          arst_ni,
    input  logic [31:0]                   instr_i,
    input  logic                          instr_valid_i,
    output logic                          instr_ready_o,
    input  logic                          wb_en_i,
    input  logic [REG_AW-1:0]             wb_addr_i,
    input  logic [DATA_WIDTH-1:0]         wb_data_i,
    output logic                          ex_valid_o,
    input  logic                          ex_ready_i,
    output decode_issue_pkg::func_t       func_o,
    output logic [DATA_WIDTH-1:0]         rs1_data_o,
    output logic [DATA_WIDTH-1:0]         rs2_data_o,
    output logic [5:0]                    imm_o,
    output logic [REG_AW-1:0]             rd_addr_o,
    output logic                          illegal_o
);
    import decode_issue_pkg::*;

    logic [3:0]            opcode;
    logic [REG_AW-1:0]     rd, rs1, rs2;
    logic [5:0]            imm;
    logic                  legal, uses_rs2, hazard, accept, issue;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy, busy_now, busy_nxt;
    logic [DATA_WIDTH-1:0] rs1_val, rs2_val;
    logic [6:0]            unused_hi;

    assign opcode    = instr_i[3:0];
    assign rd        = REG_AW'(instr_i[8:4]);
    assign rs1       = REG_AW'(instr_i[13:9]);
    assign rs2       = REG_AW'(instr_i[18:14]);
    assign imm       = instr_i[24:19];
    assign unused_hi = instr_i[31:25];
    assign legal     = (opcode <= 4'd10);

    always_comb begin
        case (func_t'(opcode))
            FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_SLL, FUNC_SLR: uses_rs2 = 1'b1;
            default: uses_rs2 = 1'b0;
        endcase
    end

    // With bypass, a register being written back this cycle is no longer a hazard.
    always_comb begin
        busy_now = busy;
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en_i) busy_now[wb_addr_i] = 1'b0;
`endif
    end

    always_comb begin
        rs1_val = regs[rs1];
        rs2_val = regs[rs2];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en_i && wb_addr_i == rs1) rs1_val = wb_data_i;
        if (wb_en_i && wb_addr_i == rs2) rs2_val = wb_data_i;
`endif
        if (rs1 == '0) rs1_val = '0;
        if (rs2 == '0) rs2_val = '0;
    end

    // Illegal words use no sources, so they are dropped without stalling.
    assign hazard        = legal & (busy_now[rs1] | (uses_rs2 & busy_now[rs2]));
    assign instr_ready_o = (~ex_valid_o | ex_ready_i) & ~hazard;
    assign accept        = instr_valid_i & instr_ready_o;
    assign issue         = accept & legal;

    // Clear first, then set, so a same-register set/clear leaves it busy.
    always_comb begin
        busy_nxt = busy;
        if (wb_en_i) busy_nxt[wb_addr_i] = 1'b0;
        if (issue && rd != '0) busy_nxt[rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_en_i && wb_addr_i != '0) begin
            regs[wb_addr_i] <= wb_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) busy <= '0;
        else          busy <= busy_nxt;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            ex_valid_o <= 1'b0;
            illegal_o  <= 1'b0;
            func_o     <= FUNC_ADD;
            rs1_data_o <= '0;
            rs2_data_o <= '0;
            imm_o      <= '0;
            rd_addr_o  <= '0;
        end else begin
            illegal_o <= accept & ~legal;
            if (issue) begin
                ex_valid_o <= 1'b1;
                func_o     <= func_t'(opcode);
                rs1_data_o <= rs1_val;
                rs2_data_o <= rs2_val;
                imm_o      <= imm;
                rd_addr_o  <= rd;
            end else if (ex_ready_i) begin
                ex_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Decode/operand-fetch stage directly upstream of `merge_execution`.
- Accepts 32-bit instructions from fetch over a valid/ready handshake and decodes them to `func_t`, register addresses and a 6-bit immediate.
- Reads operands from an internal register file, which the writeback port writes.
- Blocks RAW hazards with a scoreboard and presents one registered issue slot to execution.

Parameters:
- NUM_REGS, 32, number of architectural registers; r0 reads zero.
- REG_AW, $clog2(NUM_REGS), register address width.
- DATA_WIDTH, package value, operand width.

Ports:
- clk_i  in  1  clock
- arst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- instr_i  in  32  instruction word from fetch
- instr_valid_i  in  1  instr_i valid
- instr_ready_o  out  1  stage accepts instr_i this cycle
- wb_en_i  in  1  register write strobe from writeback
- wb_addr_i  in  REG_AW  destination register
- wb_data_i  in  DATA_WIDTH  write data
- ex_valid_o  out  1  issue slot holds an instruction
- ex_ready_i  in  1  execution consumes the slot
- func_o  out  func_t  decoded operation
- rs1_data_o  out  DATA_WIDTH  operand 1
- rs2_data_o  out  DATA_WIDTH  operand 2
- imm_o  out  6  immediate
- rd_addr_o  out  REG_AW  destination register
- illegal_o  out  1  pulse: unknown opcode dropped

Behaviour:
- Encoding:
  - [3:0] opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 ADDI, 7 SLL, 8 SLLI, 9 SLR, 10 SLRI.
  - [8:4] rd, [13:9] rs1, [18:14] rs2, [24:19] imm; [31:25] ignored.
- Source use:
  - rs2 is used by ADD/SUB/AND/OR/XOR/SLL/SLR.
  - rs1 is used by all opcodes.
  - Every opcode writes rd.
- Scoreboard:
  - One busy bit per register.
  - r0 is never busy and always reads 0.
  - Writes to r0 are ignored.
- Hazard: a used source register is busy and not cleared this cycle.
- Handshake:
  - instr_ready_o = (!ex_valid_o | ex_ready_i) & !hazard.
  - Accept happens when instr_valid_i & instr_ready_o.
- On accept, with a legal opcode, on the next edge:
  - Register func/imm/rd and the operands read this cycle.
  - Set ex_valid_o=1.
  - Set busy[rd] (rd≠0).
- On accept with an illegal opcode:
  - Consume the word; do not issue; do not mark busy.
  - illegal_o=1 for exactly one cycle (registered).
- Slot: when ex_valid_o & ex_ready_i with no new accept, ex_valid_o→0 next cycle. Outputs hold stable while ex_valid_o & !ex_ready_i.
- Writeback: wb_en_i writes regfile[wb_addr_i] at the edge and clears busy[wb_addr_i].
- Simultaneous set and clear of the same register: set wins (register stays busy).
- Latency: accept→ex_valid_o is 1 cycle; throughput is 1/cycle without hazards.
- Reset (async, arst_ni=0):
  - All registers, busy bits and ex_valid_o cleared.
  - illegal_o=0, func_o=ADD, all data/address outputs 0.
  - instr_ready_o follows its equation, so it is 1 in reset.
  - A slot held during reset is dropped.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined:
  - An operand whose register matches wb_addr_i with wb_en_i=1 takes wb_data_i in the same cycle.
  - That register counts as not busy this cycle.
  - RAW stall ends in the writeback cycle.
- Undefined:
  - Operand reads see only the stored regfile.
  - Busy clears at the edge, so the dependent instruction is accepted one cycle after writeback.

Test Plan:
- Reset, then write r1=0xA5A5A5A5 and r2=0x5A5A5A5A via wb; issue AND rd=3 rs1=1 rs2=2 → next cycle ex_valid_o=1, func_o=AND, rs1_data_o=0xA5A5A5A5, rs2_data_o=0x5A5A5A5A, rd_addr_o=3.
- Issue ADDI rd=4 rs1=1 imm=3, then ADD rd=5 rs1=4 rs2=0 → second word stalls (instr_ready_o=0). Then wb r4=4 → accepted in the wb cycle with rs1_data_o=4 (bypass on), or one cycle later (bypass off).
- Hold ex_ready_i=0 for 3 cycles with instr_valid_i=1 → func_o/data stable and instr_ready_o=0; on release, one cycle per instruction.
- Opcode 15 → illegal_o pulses 1 cycle, ex_valid_o stays 0, scoreboard unchanged.
- wb r0=0xFFFFFFFF, then issue SLL rs1=0 → rs1_data_o=0, no stall.
- Assert arst_ni=0 while a slot is valid and r6 is busy → ex_valid_o=0 immediately; after release, an instruction reading r6 issues with rs1_data_o=0 and no stall.
